// File: rtl/axi_demux_1_n_reg_if.sv
// Bus bundle for the registered 1-to-N response/data demultiplexer.
// Carries the upstream valid/ready stream and the N downstream ports.
interface axi_demux_1_n_reg_if #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2
);
    logic                          s_valid;
    logic                          s_ready;
    logic [SEL_WIDTH-1:0]          s_sel;
    logic [DATA_WIDTH-1:0]         s_data;
    logic [NUM_OUT-1:0]            m_valid;
    logic [NUM_OUT-1:0]            m_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] m_data;

    // Demux side: consumes the upstream stream, drives the downstream ports.
    modport slave (
        input  s_valid, s_sel, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment side: produces the upstream stream, sinks the ports.
    modport master (
        output s_valid, s_sel, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/axi_demux_1_n_reg.sv
// Registered 1-to-N demultiplexer for AXI B/R return channels.
// One output register plus a one-entry skid register give full throughput
// with s_ready driven straight from a flop. Beats whose select does not name
// a real port are swallowed at acceptance and counted.
module axi_demux_1_n_reg #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axi_demux_1_n_reg_if.slave    bus,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [SEL_WIDTH:0] NUM_OUT_W = (SEL_WIDTH + 1)'(NUM_OUT);

    logic                  or_valid_q, or_valid_d;
    logic [SEL_WIDTH-1:0]  or_sel_q,   or_sel_d;
    logic [DATA_WIDTH-1:0] or_data_q,  or_data_d;
    logic                  sk_valid_q, sk_valid_d;
    logic [SEL_WIDTH-1:0]  sk_sel_q,   sk_sel_d;
    logic [DATA_WIDTH-1:0] sk_data_q,  sk_data_d;
    logic                  s_ready_q,  s_ready_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

    logic [NUM_OUT-1:0]            or_sel_oh;
    logic [NUM_OUT*DATA_WIDTH-1:0] m_data_c;
    logic                          or_xfer;
    logic                          accept;
    logic                          in_range;
    logic                          acc_ok;
    logic                          acc_drop;

    // Decode the held beat into a one-hot valid vector and gate the payload.
    always_comb begin
        or_sel_oh = '0;
        m_data_c  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (or_valid_q && (or_sel_q == SEL_WIDTH'(i))) begin
                or_sel_oh[i]                          = 1'b1;
                m_data_c[i*DATA_WIDTH +: DATA_WIDTH]  = or_data_q;
            end
        end
    end

    // Next-state for output register, skid register, ready and drop stats.
    always_comb begin
        or_xfer  = |(or_sel_oh & bus.m_ready);
        accept   = bus.s_valid & s_ready_q;
        in_range = ({1'b0, bus.s_sel} < NUM_OUT_W);
        acc_ok   = accept & in_range;
        acc_drop = accept & ~in_range;

        or_valid_d   = or_valid_q;
        or_sel_d     = or_sel_q;
        or_data_d    = or_data_q;
        sk_valid_d   = sk_valid_q;
        sk_sel_d     = sk_sel_q;
        sk_data_d    = sk_data_q;
        drop_pulse_d = acc_drop;
        drop_count_d = drop_count_q;

        if (!or_valid_q || or_xfer) begin
            // Skid entry is always older than anything arriving now; while it
            // is full s_ready is low, so no accept can coincide with it.
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_sel_d   = sk_sel_q;
                or_data_d  = sk_data_q;
                sk_valid_d = 1'b0;
            end else if (acc_ok) begin
                or_valid_d = 1'b1;
                or_sel_d   = bus.s_sel;
                or_data_d  = bus.s_data;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (acc_ok) begin
            sk_valid_d = 1'b1;
            sk_sel_d   = bus.s_sel;
            sk_data_d  = bus.s_data;
        end

        if (acc_drop && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + 1'b1;
        end

        s_ready_d = ~sk_valid_d;
    end

    // All state lives here; reset empties both registers and holds off ready.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            or_valid_q   <= 1'b0;
            or_sel_q     <= '0;
            or_data_q    <= '0;
            sk_valid_q   <= 1'b0;
            sk_sel_q     <= '0;
            sk_data_q    <= '0;
            s_ready_q    <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            or_valid_q   <= or_valid_d;
            or_sel_q     <= or_sel_d;
            or_data_q    <= or_data_d;
            sk_valid_q   <= sk_valid_d;
            sk_sel_q     <= sk_sel_d;
            sk_data_q    <= sk_data_d;
            s_ready_q    <= s_ready_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = or_sel_oh;
    assign bus.m_data   = m_data_c;
    assign drop_pulse   = drop_pulse_q;
    assign drop_count   = drop_count_q;

endmodule

// File: doc/axi_demux_1_n_reg.md
Name: axi_demux_1_n_reg

Overview:
Registered, parametrised 1-to-N demultiplexer for AXI response/data channels (B, R) in the interconnect return path. It routes one upstream valid/ready stream to one of NUM_OUT downstream ports, selected by a per-beat select field. Full valid/ready handshaking and a 2-entry skid buffer give 1 beat/cycle throughput with no combinational ready path. Out-of-range selects are absorbed and counted rather than routed.

Parameters:
NUM_OUT, 4, number of output ports (2..16)
DATA_WIDTH, 32, payload width (2 for BRESP, DATA+RESP+LAST for R)
SEL_WIDTH, 2, select width; must satisfy 2**SEL_WIDTH >= NUM_OUT
CNT_WIDTH, 16, width of drop counter

Ports:
ACLK  input  1  clock, all state on rising edge
ARESETN  input  1  asynchronous active-low reset
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream ready; registered
s_sel  input  SEL_WIDTH  destination port index
s_data  input  DATA_WIDTH  upstream payload
m_valid  output  NUM_OUT  per-port valid, one-hot or zero
m_ready  input  NUM_OUT  per-port ready
m_data  output  NUM_OUT*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
drop_pulse  output  1  one-cycle pulse when an out-of-range beat is discarded
drop_count  output  CNT_WIDTH  saturating count of discarded beats

Behaviour:
- Reset (ARESETN=0, async): m_valid=0, m_data=0, s_ready=0, drop_pulse=0, drop_count=0, skid and output registers empty. s_ready goes 1 on the first ACLK edge after deassertion.
- Handshake: upstream beat accepted when s_valid & s_ready at an ACLK edge. Port i transfer when m_valid[i] & m_ready[i].
- Storage: output register (OR: valid, sel, data) + skid register (SK). s_ready = !SK.valid (registered).
- Latency: beat accepted at edge k appears on m_valid/m_data at edge k (visible cycle k+1) when OR empty or draining; 1 cycle minimum.
- OR load: on edge where OR empty or its port transfers: load from SK if SK valid, else from accepted input, else OR empties.
- SK load: accepted input while OR holds and does not transfer -> SK. SK never overwritten while valid.
- Ordering: strict FIFO order across all ports; beat for port j blocks behind stalled beat for port i (no reordering).
- Data gating: m_data for non-selected ports driven all-zero; selected port carries OR.data. m_valid never has >1 bit set.
- m_valid/m_data stable while m_ready for the held port is low (AXI rule: no withdrawal of valid).
- Out-of-range: accepted beat with s_sel >= NUM_OUT never enters OR/SK; it is discarded at acceptance, drop_pulse=1 next cycle, drop_count +1 saturating at all-ones. Does not consume a slot nor disturb in-flight beats.
- Simultaneous: OR drain + SK move + new accept in same edge is legal; sustains 1 beat/cycle with all m_ready high.
- ARESETN asserted mid-transfer: all in-flight beats lost, outputs to reset values immediately.
- Unused select bit codes when NUM_OUT < 2**SEL_WIDTH follow the out-of-range rule.

Test Plan:
- Reset: hold ARESETN=0, drive s_valid=1 -> m_valid=0000, s_ready=0, drop_count=0; release -> s_ready=1 after one edge.
- Routing, NUM_OUT=4, DATA_WIDTH=32: send sel=0..3 with data 32'hAAAA0000+sel, all m_ready=1 -> each beat on m_valid one-hot (0001,0010,0100,1000) one cycle later with matching data; other slices 32'h0.
- Backpressure: m_ready[2]=0, send beats sel=2 (32'h11111111), sel=1 (32'h22222222), sel=3 -> first held stable on port 2, second in SK, s_ready=0, third stalled; raise m_ready[2] -> beats emerge in order, no loss/duplication.
- Streaming: 100 back-to-back beats random sel 0..3, all m_ready=1 -> 100 transfers in 101 cycles, order preserved, scoreboard match.
- Out-of-range, NUM_OUT=3, SEL_WIDTH=2: send sel=3 data 32'hDEADBEEF between two valid beats -> drop_pulse 1 cycle, drop_count=1, neighbours delivered; CNT_WIDTH=2 with 5 drops -> drop_count=3.
- Reset mid-operation: OR and SK full, stalled, assert ARESETN -> m_valid=0 asynchronously; after release, next beat (sel=1, 32'h5) delivered with nothing stale.
